// File: rtl/seg_display_driver.sv
// Multiplexed 7-segment display back end: double-buffered frame loads, one-hot digit scan and flash blanking.
// Optional feature macro: GHOST_BLANK_EN (8-cycle dead time at the start of every digit slot).
module seg_display_driver #(
    parameter int DIGITS       = 5,
    parameter int CLK_DIV      = 4000,
    parameter int FLASH_FRAMES = 250
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [8*DIGITS-1:0] disp_data,
    input  logic [2:0]          disp_mode,
    input  logic                disp_load,
    output logic                load_ack,
    output logic [DIGITS-1:0]   dig_sel,
    output logic [7:0]          seg_out,
    output logic [2:0]          flash_cnt
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_FLASH = 2'd1,
        MODE_BLANK = 2'd2
    } mode_e;

    function automatic mode_e decode_mode(input logic [2:0] m);
        case (m)
            3'd0:    decode_mode = MODE_CONST;
            3'd1:    decode_mode = MODE_FLASH;
            default: decode_mode = MODE_BLANK;
        endcase
    endfunction

    logic [DW-1:0]       div_cnt_q, div_cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [8*DIGITS-1:0] act_data_q, act_data_d, sh_data_q, sh_data_d;
    mode_e               act_mode_q, act_mode_d, sh_mode_q, sh_mode_d;
    logic                pending_q, pending_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic                phase_off_q, phase_off_d;
    logic [2:0]          flash_cnt_q, flash_cnt_d;
    logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic [7:0]          seg_q, seg_d;
    logic                load_ack_q, load_ack_d;
    logic                slot_end_s, frame_end_s, visible_s;

    // Next-state logic: scan timing, load handshake, flash sequencing and output decode.
    always_comb begin
        slot_end_s  = (div_cnt_q == DW'(CLK_DIV - 1));
        frame_end_s = slot_end_s && (idx_q == IW'(DIGITS - 1));
        div_cnt_d   = div_cnt_q;
        idx_d       = idx_q;
        act_data_d  = act_data_q;
        act_mode_d  = act_mode_q;
        sh_data_d   = sh_data_q;
        sh_mode_d   = sh_mode_q;
        pending_d   = pending_q;
        frame_d     = frame_q;
        phase_off_d = phase_off_q;
        flash_cnt_d = flash_cnt_q;
        load_ack_d  = 1'b0;
        dig_sel_d   = '0;
        seg_d       = 8'h00;

        if (slot_end_s) begin
            div_cnt_d = '0;
            if (idx_q == IW'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end

        // A phase toggle from off back to visible completes one flash cycle.
        if (frame_end_s && (act_mode_q == MODE_FLASH)) begin
            if (frame_q == FW'(FLASH_FRAMES - 1)) begin
                frame_d     = '0;
                phase_off_d = !phase_off_q;
                if (phase_off_q && (flash_cnt_q != 3'd7)) begin
                    flash_cnt_d = flash_cnt_q + 3'd1;
                end else begin
                    flash_cnt_d = flash_cnt_q;
                end
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end else begin
            frame_d = frame_q;
        end

        // The apply uses the old shadow; a coincident load refills it and keeps pending set.
        if (frame_end_s && pending_q) begin
            act_data_d = sh_data_q;
            act_mode_d = sh_mode_q;
            pending_d  = 1'b0;
            load_ack_d = 1'b1;
            if (sh_mode_q != act_mode_q) begin
                frame_d     = '0;
                phase_off_d = 1'b0;
                flash_cnt_d = 3'd0;
            end else begin
                flash_cnt_d = flash_cnt_d;
            end
        end else begin
            load_ack_d = 1'b0;
        end

        if (disp_load) begin
            sh_data_d = disp_data;
            sh_mode_d = decode_mode(disp_mode);
            pending_d = 1'b1;
        end else begin
            sh_data_d = sh_data_q;
        end

        visible_s = (act_mode_q == MODE_CONST) ||
                    ((act_mode_q == MODE_FLASH) && !phase_off_q);
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                dig_sel_d[i] = 1'b1;
                seg_d        = visible_s ? act_data_q[8*i +: 8] : 8'h00;
            end else begin
                dig_sel_d[i] = 1'b0;
            end
        end
`ifdef GHOST_BLANK_EN
        if (div_cnt_q < DW'(8)) begin
            dig_sel_d = '0;
            seg_d     = 8'h00;
        end else begin
            seg_d = seg_d;
        end
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt_q   <= '0;
            idx_q       <= '0;
            act_data_q  <= '0;
            act_mode_q  <= MODE_CONST;
            sh_data_q   <= '0;
            sh_mode_q   <= MODE_CONST;
            pending_q   <= 1'b0;
            frame_q     <= '0;
            phase_off_q <= 1'b0;
            flash_cnt_q <= 3'd0;
            dig_sel_q   <= '0;
            seg_q       <= 8'h00;
            load_ack_q  <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            idx_q       <= idx_d;
            act_data_q  <= act_data_d;
            act_mode_q  <= act_mode_d;
            sh_data_q   <= sh_data_d;
            sh_mode_q   <= sh_mode_d;
            pending_q   <= pending_d;
            frame_q     <= frame_d;
            phase_off_q <= phase_off_d;
            flash_cnt_q <= flash_cnt_d;
            dig_sel_q   <= dig_sel_d;
            seg_q       <= seg_d;
            load_ack_q  <= load_ack_d;
        end
    end

    assign load_ack  = load_ack_q;
    assign dig_sel   = dig_sel_q;
    assign seg_out   = seg_q;
    assign flash_cnt = flash_cnt_q;
endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver: directed scenarios plus random loads against a cycle-count model.
module tb_seg_display_driver;
    localparam int DIGITS = 5;
    localparam int CLK_DIV = 4;
    localparam int FF = 2;
    localparam int FRAME = CLK_DIV * DIGITS;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [39:0] disp_data = 40'h0;
    logic [2:0]  disp_mode = 3'd0;
    logic        disp_load = 1'b0;
    logic        load_ack;
    logic [4:0]  dig_sel;
    logic [7:0]  seg_out;
    logic [2:0]  flash_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: cycles since reset release, active/shadow frames, frames spent flashing.
    int          n;
    logic [39:0] m_act, m_sh;
    int          m_amode, m_smode;
    bit          m_pend;
    int          m_f;

    seg_display_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .FLASH_FRAMES(FF)) dut (
        .clk(clk), .reset(reset), .disp_data(disp_data), .disp_mode(disp_mode),
        .disp_load(disp_load), .load_ack(load_ack), .dig_sel(dig_sel),
        .seg_out(seg_out), .flash_cnt(flash_cnt)
    );

    always #5 clk = ~clk;

    function automatic int mclass(input logic [2:0] m);
        return (m == 3'd0) ? 0 : ((m == 3'd1) ? 1 : 2);
    endfunction

    function automatic int m_fc();
        int c;
        c = m_f / (2 * FF);
        return (c > 7) ? 7 : c;
    endfunction

    task automatic step(input bit ld, input logic [39:0] d, input logic [2:0] md);
        int idx;
        bit fe, vis;
        logic [4:0] e_dig;
        logic [7:0] e_seg;
        logic       e_ack;
        logic [2:0] e_fc;
        disp_load = ld;
        disp_data = d;
        disp_mode = md;
        @(posedge clk);
        if (!reset) begin
            n = 0; m_act = 40'h0; m_sh = 40'h0; m_amode = 0; m_smode = 0; m_pend = 0; m_f = 0;
            e_dig = 5'b0; e_seg = 8'h00; e_ack = 1'b0;
        end else begin
            idx   = (n / CLK_DIV) % DIGITS;
            fe    = ((n % FRAME) == FRAME - 1);
            vis   = (m_amode == 0) || ((m_amode == 1) && (((m_f / FF) % 2) == 0));
            e_dig = 5'b00001 << idx;
            e_seg = vis ? m_act[8*idx +: 8] : 8'h00;
            e_ack = fe && m_pend;
            if (fe && m_amode == 1) m_f++;
            if (fe && m_pend) begin
                if (m_smode != m_amode) m_f = 0;
                m_act = m_sh; m_amode = m_smode; m_pend = 0;
            end
            if (ld) begin
                m_sh = d; m_smode = mclass(md); m_pend = 1;
            end
            n++;
        end
        e_fc = 3'(m_fc());
        #1;
        checks += 4;
        assert (dig_sel === e_dig) else begin
            errors++; $error("FAIL dig_sel n=%0d got %b exp %b", n, dig_sel, e_dig);
        end
        assert (seg_out === e_seg) else begin
            errors++; $error("FAIL seg_out n=%0d got %h exp %h", n, seg_out, e_seg);
        end
        assert (load_ack === e_ack) else begin
            errors++; $error("FAIL load_ack n=%0d got %b exp %b", n, load_ack, e_ack);
        end
        assert (flash_cnt === e_fc) else begin
            errors++; $error("FAIL flash_cnt n=%0d got %0d exp %0d", n, flash_cnt, e_fc);
        end
        disp_load = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) step(1'b0, 40'h0, 3'd0);
    endtask

    function automatic logic [39:0] rnd40();
        return {8'($urandom), 32'($urandom)};
    endfunction

    initial begin
        logic [39:0] a, b;
        n = 0; m_act = 40'h0; m_sh = 40'h0; m_amode = 0; m_smode = 0; m_pend = 0; m_f = 0;

        // Reset state, then constant-mode load of the reference pattern.
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        step(1'b1, 40'h3F_06_5B_4F_66, 3'd0);
        idle(2 * FRAME + 5);

        // Two loads in one frame: only the second is applied, with one ack.
        while ((n % FRAME) != 2) step(1'b0, 40'h0, 3'd0);
        a = rnd40(); b = rnd40();
        step(1'b1, a, 3'd0);
        idle(5);
        step(1'b1, b, 3'd0);
        idle(2 * FRAME);

        // Flash mode runs long enough to saturate flash_cnt.
        step(1'b1, rnd40(), 3'd1);
        idle(36 * FRAME);
        checks++;
        assert (flash_cnt === 3'd7) else begin
            errors++; $error("FAIL flash_sat got %0d exp 7", flash_cnt);
        end

        // Restart flashing, stop at flash_cnt=3, switch to constant, then reapply constant.
        step(1'b1, rnd40(), 3'd0);
        idle(2 * FRAME);
        step(1'b1, rnd40(), 3'd1);
        for (int k = 0; k < 60 * FRAME && m_fc() < 3; k++) step(1'b0, 40'h0, 3'd0);
        checks++;
        assert (flash_cnt === 3'd3) else begin
            errors++; $error("FAIL flash_cnt3 got %0d exp 3", flash_cnt);
        end
        step(1'b1, rnd40(), 3'd0);
        idle(2 * FRAME);
        checks++;
        assert (flash_cnt === 3'd0) else begin
            errors++; $error("FAIL mode_clear got %0d exp 0", flash_cnt);
        end
        step(1'b1, rnd40(), 3'd0);
        idle(2 * FRAME);

        // Load landing exactly on the frame_end cycle while another frame is pending.
        while ((n % FRAME) != 5) step(1'b0, 40'h0, 3'd0);
        step(1'b1, rnd40(), 3'd0);
        while ((n % FRAME) != FRAME - 1) step(1'b0, 40'h0, 3'd0);
        step(1'b1, rnd40(), 3'd7);
        idle(2 * FRAME + 3);

        // Reset mid-slot during flash; scan restarts with blank content.
        step(1'b1, rnd40(), 3'd1);
        idle(6 * FRAME);
        while ((n % CLK_DIV) != 2) step(1'b0, 40'h0, 3'd0);
        reset = 1'b0;
        step(1'b0, 40'h0, 3'd0);
        reset = 1'b1;
        idle(FRAME + 7);

        // Random loads with mixed modes.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 14) == 0) step(1'b1, rnd40(), 3'($urandom_range(0, 4)));
            else step(1'b0, 40'h0, 3'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
